// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-master RAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Round-robin choice: on conflict the master that did not win last time goes.
  function automatic logic pick(input logic req0, input logic req1, input logic last_gnt);
    logic winner;
    if (req0 && req1) begin
      winner = ~last_gnt;
    end else if (req1) begin
      winner = M1;
    end else begin
      winner = M0;
    end
    return winner;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with bounded lock sharing one single-port RAM
// (1-cycle read latency) between two masters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_LOCK) + 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(MAX_LOCK - 1);

  arb_state_e        state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_id_q, rd_id_d;
  logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
  logic [DATA_W-1:0] wdata_hold_q, wdata_hold_d;

  logic              gnt_valid;
  logic              gnt_id;
  logic              sel_we;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              owner_lock;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ARB;
      last_gnt_q   <= M1;
      lock_cnt_q   <= '0;
      rd_pend_q    <= 1'b0;
      rd_id_q      <= M0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      last_gnt_q   <= last_gnt_d;
      lock_cnt_q   <= lock_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_id_q      <= rd_id_d;
      addr_hold_q  <= addr_hold_d;
      wdata_hold_q <= wdata_hold_d;
    end
  end

  // Grants are gated by reset so nothing reaches the RAM while it is held.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    lock_cnt_d = lock_cnt_q;
    gnt_valid  = 1'b0;
    gnt_id     = M0;
    owner_lock = 1'b0;

    case (state_q)
      ARB: begin
        gnt_valid = reset && (m0_req || m1_req);
        gnt_id    = pick(m0_req, m1_req, last_gnt_q);
      end
      LOCK0: begin
        gnt_valid  = reset && m0_req;
        gnt_id     = M0;
        owner_lock = m0_lock;
      end
      LOCK1: begin
        gnt_valid  = reset && m1_req;
        gnt_id     = M1;
        owner_lock = m1_lock;
      end
      default: begin
        gnt_valid = 1'b0;
      end
    endcase

    sel_we    = (gnt_id == M1) ? m1_we    : m0_we;
    sel_lock  = (gnt_id == M1) ? m1_lock  : m0_lock;
    sel_addr  = (gnt_id == M1) ? m1_addr  : m0_addr;
    sel_wdata = (gnt_id == M1) ? m1_wdata : m0_wdata;

    if (gnt_valid) begin
      last_gnt_d = gnt_id;
    end

    // Lock only starts from a fresh ARB grant; an exit cycle never re-locks.
    if (state_q == ARB) begin
      if (gnt_valid && sel_lock) begin
        state_d    = (gnt_id == M1) ? LOCK1 : LOCK0;
        lock_cnt_d = CNT_W'(1);
      end
    end else begin
      lock_cnt_d = lock_cnt_q + CNT_W'(1);
      if (!owner_lock || (lock_cnt_q == LOCK_LAST)) begin
        state_d    = ARB;
        lock_cnt_d = '0;
      end
    end
  end

  always_comb begin
    rd_pend_d    = gnt_valid && !sel_we;
    rd_id_d      = gnt_valid ? gnt_id : rd_id_q;
    addr_hold_d  = gnt_valid ? sel_addr : addr_hold_q;
    wdata_hold_d = gnt_valid ? sel_wdata : wdata_hold_q;
  end

  assign m0_gnt    = gnt_valid && (gnt_id == M0);
  assign m1_gnt    = gnt_valid && (gnt_id == M1);
  assign mem_we    = gnt_valid && sel_we;
  assign mem_addr  = gnt_valid ? sel_addr : addr_hold_q;
  assign mem_wdata = gnt_valid ? sel_wdata : wdata_hold_q;

  assign m0_rvalid = rd_pend_q && (rd_id_q == M0);
  assign m1_rvalid = rd_pend_q && (rd_id_q == M1);
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule
